// File: rtl/dec_width_converter_32to16.sv
// Splits each source word into two output half-words, upper half first, with
// valid/ready handshakes. Define DEC_WCONV_REG_READY_EN for a skid entry and a flop-driven ready.
module dec_width_converter_32to16 #(
  parameter int unsigned InputDataWidth  = 32,
  parameter int unsigned OutputDataWidth = 16
) (
  input  logic                       iClock,
  input  logic                       iReset,
  input  logic                       iSrcDataValid,
  input  logic                       iSrcDataLast,
  input  logic [InputDataWidth-1:0]  iSrcData,
  output logic                       oConverterReady,
  output logic                       oConvertedDataValid,
  output logic                       oConvertedDataLast,
  output logic [OutputDataWidth-1:0] oConvertedData,
  input  logic                       iDstReady
);

  localparam int unsigned IW = InputDataWidth;
  localparam int unsigned OW = OutputDataWidth;

  localparam logic [2:0] StIdle = 3'b001;
  localparam logic [2:0] StHigh = 3'b010;
  localparam logic [2:0] StLow  = 3'b100;

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] data_q, data_d;
  logic          last_q, last_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [OW-1:0] out_data_q, out_data_d;
  logic          ready;
  logic          in_xfer;
  logic          out_xfer;

`ifdef DEC_WCONV_REG_READY_EN
  logic          skid_valid_q, skid_valid_d;
  logic [IW-1:0] skid_data_q, skid_data_d;
  logic          skid_last_q, skid_last_d;
  logic          ready_q, ready_d;

  assign ready = ready_q;
`else
  // Ready looks through to the sink so a new word can load on the final half.
  assign ready = (state_q == StIdle) || ((state_q == StLow) && iDstReady);
`endif

  assign in_xfer  = iSrcDataValid && ready;
  assign out_xfer = out_valid_q && iDstReady;

  // Next-state, buffer and output computation.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    last_d  = last_q;
`ifdef DEC_WCONV_REG_READY_EN
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
`endif
    case (state_q)
      StIdle: begin
        if (in_xfer) begin
          data_d  = iSrcData;
          last_d  = iSrcDataLast;
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (out_xfer) state_d = StLow;
`ifdef DEC_WCONV_REG_READY_EN
        if (in_xfer) begin
          skid_valid_d = 1'b1;
          skid_data_d  = iSrcData;
          skid_last_d  = iSrcDataLast;
        end
`endif
      end
      StLow: begin
        if (out_xfer) begin
`ifdef DEC_WCONV_REG_READY_EN
          if (skid_valid_q) begin
            data_d       = skid_data_q;
            last_d       = skid_last_q;
            skid_valid_d = 1'b0;
            state_d      = StHigh;
          end else
`endif
          if (in_xfer) begin
            data_d  = iSrcData;
            last_d  = iSrcDataLast;
            state_d = StHigh;
          end else begin
            state_d = StIdle;
          end
        end
`ifdef DEC_WCONV_REG_READY_EN
        else if (in_xfer) begin
          skid_valid_d = 1'b1;
          skid_data_d  = iSrcData;
          skid_last_d  = iSrcDataLast;
        end
`endif
      end
      default: state_d = StIdle;
    endcase

`ifdef DEC_WCONV_REG_READY_EN
    ready_d = ~skid_valid_d;
`endif

    out_valid_d = (state_d == StHigh) || (state_d == StLow);
    out_last_d  = (state_d == StLow) && last_d;
    if (state_d == StHigh)     out_data_d = data_d[IW-1:OW];
    else if (state_d == StLow) out_data_d = data_d[OW-1:0];
    else                       out_data_d = '0;
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q     <= StIdle;
      data_q      <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
`ifdef DEC_WCONV_REG_READY_EN
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      ready_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
`ifdef DEC_WCONV_REG_READY_EN
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      ready_q      <= ready_d;
`endif
    end
  end

  assign oConverterReady     = ready;
  assign oConvertedDataValid = out_valid_q;
  assign oConvertedDataLast  = out_last_q;
  assign oConvertedData      = out_data_q;

endmodule

// File: tb/tb_dec_width_converter_32to16.sv
// Scoreboard bench for dec_width_converter_32to16: expected half-words are queued
// on each input transfer and compared on each output transfer.
module tb_dec_width_converter_32to16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        src_valid = 1'b0;
  logic        src_last = 1'b0;
  logic [31:0] src_data = '0;
  logic        dst_ready = 1'b1;
  logic        ready;
  logic        ovalid;
  logic        olast;
  logic [15:0] odata;

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [17:0] prev_out = '0;
  logic        rand_done;

  dec_width_converter_32to16 dut (
    .iClock             (clk),
    .iReset             (rst),
    .iSrcDataValid      (src_valid),
    .iSrcDataLast       (src_last),
    .iSrcData           (src_data),
    .oConverterReady    (ready),
    .oConvertedDataValid(ovalid),
    .oConvertedDataLast (olast),
    .oConvertedData     (odata),
    .iDstReady          (dst_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard and hold monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("hold", {14'd0, ovalid, olast, odata}, {14'd0, prev_out});
      if (ovalid && dst_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", {15'd0, olast, odata}, 32'hFFFF_FFFF);
        else check("out_half", {15'd0, olast, odata}, {15'd0, exp_q.pop_front()});
      end
      if (src_valid && ready) begin
        exp_q.push_back({1'b0, src_data[31:16]});
        exp_q.push_back({src_last, src_data[15:0]});
      end
      prev_stall = ovalid && !dst_ready;
      prev_out   = {ovalid, olast, odata};
    end
  end

  // Offer one word and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [31:0] d, input logic l);
    bit ok = 1'b0;
    src_valid = 1'b1;
    src_data  = d;
    src_last  = l;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    src_valid = 1'b0;
    src_data  = $urandom;
    src_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] rec_d[6];
    logic        rec_v[6];
    logic [15:0] exp_d[6];
    logic        exp_v[6];
    exp_d = '{16'h0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0};
    exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset values
    tick();
    @(negedge clk);
    check("rst_valid", {31'd0, ovalid}, 32'd0);
    check("rst_last", {31'd0, olast}, 32'd0);
    check("rst_data", {16'd0, odata}, 32'd0);
`ifdef DEC_WCONV_REG_READY_EN
    check("rst_ready", {31'd0, ready}, 32'd0);
`else
    check("rst_ready", {31'd0, ready}, 32'd1);
`endif
    tick();
    rst = 1'b0;

    // Single word, latency 1
    send(32'hA5A5_1234, 1'b1);
    @(negedge clk);
    check("single_hi", {14'd0, ovalid, olast, odata}, {14'd0, 2'b10, 16'hA5A5});
    @(negedge clk);
    check("single_lo", {14'd0, ovalid, olast, odata}, {14'd0, 2'b11, 16'h1234});
    @(negedge clk);
    check("single_end", {31'd0, ovalid}, 32'd0);
    tick();

    // Back-to-back words, no bubble
    fork
      begin
        send(32'h1111_2222, 1'b0);
        send(32'h3333_4444, 1'b1);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          rec_d[i] = odata;
          rec_v[i] = ovalid;
        end
      end
    join
    for (int i = 0; i < 6; i++) begin
      check($sformatf("b2b_valid%0d", i), {31'd0, rec_v[i]}, {31'd0, exp_v[i]});
      if (exp_v[i]) check($sformatf("b2b_data%0d", i), {16'd0, rec_d[i]}, {16'd0, exp_d[i]});
    end
    tick();

    // Sink stall in High
    send(32'hDEAD_BEEF, 1'b0);
    dst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_hi", {14'd0, ovalid, olast, odata}, {14'd0, 2'b10, 16'hDEAD});
`ifndef DEC_WCONV_REG_READY_EN
      check("stall_ready", {31'd0, ready}, 32'd0);
`endif
    end
    tick();
    dst_ready = 1'b1;
    @(negedge clk);
    check("stall_release", {14'd0, ovalid, olast, odata}, {14'd0, 2'b10, 16'hDEAD});
    @(negedge clk);
    check("stall_lo", {14'd0, ovalid, olast, odata}, {14'd0, 2'b10, 16'hBEEF});
    tick();
    tick();

    // Reset while in Low discards the lower half
    send(32'hCAFE_F00D, 1'b1);
    @(negedge clk);
    check("rstmid_hi", {16'd0, odata}, 32'h0000_CAFE);
    tick();
    dst_ready = 1'b0;
    @(negedge clk);
    check("rstmid_lo", {14'd0, ovalid, olast, odata}, {14'd0, 2'b11, 16'hF00D});
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dst_ready = 1'b1;
    @(negedge clk);
    check("rstmid_valid", {31'd0, ovalid}, 32'd0);
    check("rstmid_data", {16'd0, odata}, 32'd0);
    check("rstmid_last", {31'd0, olast}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_f00d", {31'd0, ovalid}, 32'd0);
    end
    tick();

`ifdef DEC_WCONV_REG_READY_EN
    // Skid entry fills while the sink stalls
    dst_ready = 1'b0;
    send(32'h0102_0304, 1'b0);
    send(32'h0506_0708, 1'b1);
    @(negedge clk);
    check("skid_ready", {31'd0, ready}, 32'd0);
    check("skid_hold", {16'd0, odata}, 32'h0000_0102);
    tick();
    dst_ready = 1'b1;
    repeat (6) tick();
`endif

    // Random traffic with random sink stalls
    rand_done = 1'b0;
    fork
      begin
        for (int w = 0; w < 150; w++) begin
          repeat ($urandom_range(0, 2)) tick();
          send($urandom, 1'($urandom_range(0, 1)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          tick();
          dst_ready = ($urandom_range(0, 3) != 0);
        end
        dst_ready = 1'b1;
      end
    join

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("drain_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
